fp_result_collector: RTL and testbench

- Downstream stage of the serial double-precision multiplier.
- Captures the 8-byte result burst (byte valid whenever the multiplier's READY is high) and reassembles the 64-bit IEEE-754 double.
- Classifies the double and buffers it in a small FIFO behind a valid/accept handshake.
- The multiplier cannot be stalled, so this block absorbs bursts. It flags dropped or malformed words instead of back-pressuring.

---
 rtl/fp_result_collector.sv | 175 +++++++++++++++++
 tb/tb_fp_result_collector.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_collector.sv
// Reassembles the byte-serial double from the multiplier, classifies it and
// queues it in a small FIFO. Bursts are never stalled; drops and short bursts raise sticky flags.
module fp_result_collector #(
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     READY_IN,
  input  logic [7:0]               DATA_IN,
  input  logic                     OUT_ACCEPT,
  input  logic                     CLR_FLAGS,
  output logic                     OUT_VALID,
  output logic [63:0]              RESULT,
  output logic [2:0]               CLASS,
  output logic                     OVERFLOW,
  output logic                     FRAME_ERR,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  localparam logic [2:0] CLS_ZERO      = 3'd0;
  localparam logic [2:0] CLS_SUBNORMAL = 3'd1;
  localparam logic [2:0] CLS_NORMAL    = 3'd2;
  localparam logic [2:0] CLS_INF       = 3'd3;
  localparam logic [2:0] CLS_QNAN      = 3'd4;
  localparam logic [2:0] CLS_SNAN      = 3'd5;

  function automatic logic [2:0] classify(input logic [63:0] w);
    logic [10:0] e;
    logic [51:0] f;
    logic [2:0]  c;
    e = w[62:52];
    f = w[51:0];
    if (e == 11'd0) begin
      c = (f == 52'd0) ? CLS_ZERO : CLS_SUBNORMAL;
    end else if (e == 11'h7FF) begin
      if (f == 52'd0) begin
        c = CLS_INF;
      end else if (f[51]) begin
        c = CLS_QNAN;
      end else begin
        c = CLS_SNAN;
      end
    end else begin
      c = CLS_NORMAL;
    end
    return c;
  endfunction

  logic [2:0]    bc_r;
  logic [55:0]   shift_r;
  logic [63:0]   mem_data_r  [DEPTH];
  logic [2:0]    mem_class_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          out_valid_r;
  logic          overflow_r;
  logic          frame_err_r;

  logic [63:0]   word_s;
  logic [2:0]    word_class_s;
  logic          complete_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          frame_s;
  logic [LW-1:0] level_next_s;

  // Completion, handshake and occupancy decisions for this cycle
  always_comb begin
    word_s       = {DATA_IN, shift_r};
    word_class_s = classify(word_s);
    complete_s   = 1'b0;
    full_s       = 1'b0;
    frame_s      = 1'b0;
    pop_s        = out_valid_r & OUT_ACCEPT;
    if (READY_IN && (bc_r == 3'd7)) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    if (level_r == LEVEL_FULL) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
    if (!READY_IN && (bc_r != 3'd0)) begin
      frame_s = 1'b1;
    end else begin
      frame_s = 1'b0;
    end
    // A full FIFO still accepts the new word when the head leaves in the same cycle
    push_s = complete_s & (~full_s | pop_s);
    drop_s = complete_s & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Byte counter, FIFO pointers, occupancy and sticky flags
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      bc_r        <= 3'd0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (READY_IN) begin
        bc_r <= bc_r + 3'd1;
      end else begin
        bc_r <= 3'd0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r     <= level_next_s;
      out_valid_r <= (level_next_s != '0);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (CLR_FLAGS) begin
        overflow_r <= 1'b0;
      end
      if (frame_s) begin
        frame_err_r <= 1'b1;
      end else if (CLR_FLAGS) begin
        frame_err_r <= 1'b0;
      end
    end
  end

  // Holding slots for bytes 0..6; byte 7 goes straight from DATA_IN into the FIFO
  always_ff @(posedge CLK) begin
    if (READY_IN) begin
      case (bc_r)
        3'd0:    shift_r[7:0]   <= DATA_IN;
        3'd1:    shift_r[15:8]  <= DATA_IN;
        3'd2:    shift_r[23:16] <= DATA_IN;
        3'd3:    shift_r[31:24] <= DATA_IN;
        3'd4:    shift_r[39:32] <= DATA_IN;
        3'd5:    shift_r[47:40] <= DATA_IN;
        3'd6:    shift_r[55:48] <= DATA_IN;
        default: shift_r        <= shift_r;
      endcase
    end
  end

  // FIFO storage, left unreset; outputs are gated while empty
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r]  <= word_s;
      mem_class_r[wr_ptr_r] <= word_class_s;
    end
  end

  assign OUT_VALID = out_valid_r;
  assign RESULT    = out_valid_r ? mem_data_r[rd_ptr_r] : 64'd0;
  assign CLASS     = out_valid_r ? mem_class_r[rd_ptr_r] : 3'd0;
  assign OVERFLOW  = overflow_r;
  assign FRAME_ERR = frame_err_r;
  assign LEVEL     = level_r;

endmodule

// File: tb/tb_fp_result_collector.sv
// Bench for fp_result_collector: directed scenarios plus random traffic, all
// checked against a queue-based reference model of the collector.
module tb_fp_result_collector;

  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          READY_IN = 1'b0;
  logic [7:0]    DATA_IN = 8'd0;
  logic          OUT_ACCEPT = 1'b0;
  logic          CLR_FLAGS = 1'b0;
  logic          OUT_VALID;
  logic [63:0]   RESULT;
  logic [2:0]    CLASS;
  logic          OVERFLOW;
  logic          FRAME_ERR;
  logic [LW-1:0] LEVEL;

  fp_result_collector #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .READY_IN(READY_IN), .DATA_IN(DATA_IN),
    .OUT_ACCEPT(OUT_ACCEPT), .CLR_FLAGS(CLR_FLAGS), .OUT_VALID(OUT_VALID),
    .RESULT(RESULT), .CLASS(CLASS), .OVERFLOW(OVERFLOW), .FRAME_ERR(FRAME_ERR),
    .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  byte unsigned  partial_q[$];
  logic [63:0]   fifo_q[$];
  bit            m_ovf = 1'b0;
  bit            m_fe  = 1'b0;

  function automatic logic [63:0] ref_class(input logic [63:0] w);
    longint unsigned e;
    longint unsigned f;
    e = (w >> 52) % 2048;
    f = w % (64'd1 << 52);
    if (e == 0) return (f == 0) ? 64'd0 : 64'd1;
    if (e == 2047) begin
      if (f == 0) return 64'd3;
      return (f >= (64'd1 << 51)) ? 64'd4 : 64'd5;
    end
    return 64'd2;
  endfunction

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] head;
    head = (fifo_q.size() != 0) ? fifo_q[0] : 64'd0;
    chk_eq("out_valid", OUT_VALID, (fifo_q.size() != 0) ? 64'd1 : 64'd0);
    chk_eq("level", LEVEL, fifo_q.size());
    chk_eq("result", RESULT, head);
    chk_eq("class", CLASS, (fifo_q.size() != 0) ? ref_class(head) : 64'd0);
    chk_eq("overflow", OVERFLOW, m_ovf);
    chk_eq("frame_err", FRAME_ERR, m_fe);
  endtask

  task automatic step(input bit rdy, input logic [7:0] d, input bit acc, input bit clr);
    bit pop;
    bit push;
    bit set_ovf;
    bit set_fe;
    logic [63:0] w;
    READY_IN = rdy; DATA_IN = d; OUT_ACCEPT = acc; CLR_FLAGS = clr;
    pop = acc && (fifo_q.size() != 0);
    push = 1'b0; set_ovf = 1'b0; set_fe = 1'b0; w = 64'd0;
    if (rdy) begin
      partial_q.push_back(d);
      if (partial_q.size() == 8) begin
        for (int k = 0; k < 8; k++) w = w | (64'(partial_q[k]) << (8 * k));
        partial_q.delete();
        if (fifo_q.size() < DEPTH || pop) push = 1'b1;
        else set_ovf = 1'b1;
      end
    end else if (partial_q.size() != 0) begin
      partial_q.delete();
      set_fe = 1'b1;
    end
    if (pop) void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(w);
    m_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_fe  = set_fe  ? 1'b1 : (clr ? 1'b0 : m_fe);
    @(posedge CLK);
    #1;
    check_all();
  endtask

  task automatic burst(input logic [63:0] w, input bit acc_last);
    for (int k = 0; k < 8; k++) step(1'b1, w[8*k +: 8], (k == 7) ? acc_last : 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 6))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'hF0;
      4: return 8'h80;
      5: return 8'hF8;
      default: return 8'($urandom);
    endcase
  endfunction

  logic [63:0] sweep_w [5] = '{64'h8000000000000000, 64'h0000000000000001,
                               64'h7FF0000000000000, 64'h7FF8000000000001,
                               64'h7FF0000000000001};
  logic [2:0]  sweep_c [5] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5};

  initial begin
    #12;
    check_all();
    RESET_N = 1'b1;

    burst(64'h4000000000000000, 1'b0);
    chk_eq("t1_result", RESULT, 64'h4000000000000000);
    chk_eq("t1_class", CLASS, 64'd2);
    chk_eq("t1_level", LEVEL, 64'd1);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk_eq("t1_popped", OUT_VALID, 64'd0);

    for (int i = 0; i < 5; i++) begin
      burst(sweep_w[i], 1'b0);
      chk_eq("sweep_class", CLASS, sweep_c[i]);
      step(1'b0, 8'd0, 1'b1, 1'b0);
    end

    burst(64'h3FF0000000000000, 1'b0);
    burst(64'h4008000000000000, 1'b0);
    burst(64'hC010000000000000, 1'b0);
    chk_eq("ovf_level", LEVEL, 64'd2);
    chk_eq("ovf_flag", OVERFLOW, 64'd1);
    chk_eq("ovf_head0", RESULT, 64'h3FF0000000000000);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk_eq("ovf_head1", RESULT, 64'h4008000000000000);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk_eq("ovf_empty", OUT_VALID, 64'd0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk_eq("ovf_clr", OVERFLOW, 64'd0);

    for (int k = 0; k < 5; k++) step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk_eq("fe_flag", FRAME_ERR, 64'd1);
    chk_eq("fe_level", LEVEL, 64'd0);
    burst(64'h0123456789ABCDEF, 1'b0);
    chk_eq("fe_recover", RESULT, 64'h0123456789ABCDEF);
    step(1'b0, 8'd0, 1'b1, 1'b1);

    burst(64'h1111111111111111, 1'b0);
    burst(64'h2222222222222222, 1'b0);
    burst(64'h3333333333333333, 1'b1);
    chk_eq("pp_level", LEVEL, 64'd2);
    chk_eq("pp_ovf", OVERFLOW, 64'd0);
    chk_eq("pp_head", RESULT, 64'h2222222222222222);
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk_eq("pp_next", RESULT, 64'h3333333333333333);
    step(1'b0, 8'd0, 1'b1, 1'b0);

    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    burst(64'h4444444444444444, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'h55, 1'b0, 1'b0);
    chk_eq("rst_pre_fe", FRAME_ERR, 64'd1);
    chk_eq("rst_pre_level", LEVEL, 64'd1);
    #2;
    RESET_N = 1'b0;
    READY_IN = 1'b0;
    #1;
    chk_eq("rst_valid", OUT_VALID, 64'd0);
    chk_eq("rst_level", LEVEL, 64'd0);
    chk_eq("rst_ovf", OVERFLOW, 64'd0);
    chk_eq("rst_fe", FRAME_ERR, 64'd0);
    chk_eq("rst_result", RESULT, 64'd0);
    partial_q.delete();
    fifo_q.delete();
    m_ovf = 1'b0;
    m_fe = 1'b0;
    @(posedge CLK);
    #1;
    check_all();
    #1;
    RESET_N = 1'b1;
    burst(64'hBFF8000000000000, 1'b0);
    chk_eq("rst_recover", RESULT, 64'hBFF8000000000000);
    chk_eq("rst_rec_class", CLASS, 64'd2);

    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 11) != 0), rand_byte(),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
